// File: rtl/vga_capture_pkg.sv
// Shared types and helpers for the VGA frame grabber.
package vga_capture_pkg;

  // Width of the raster position counters.
  localparam int unsigned CntW = 11;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } cap_state_e;

  // 4:4:4 RGB to RGB332: keep the top 3/3/2 bits of each channel.
  function automatic logic [7:0] pack_rgb332(input logic [3:0] r, input logic [3:0] g,
                                             input logic [3:0] b);
    return {r[3:1], g[3:1], b[3:2]};
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] c);
    return (&c) ? c : c + CntW'(1);
  endfunction

endpackage

// File: rtl/vga_capture_sync_rx.sv
// Video input front end: registers the stream, finds sync edges, tracks the
// raster position and flags pixels inside the capture window.
module vga_capture_sync_rx
  import vga_capture_pkg::*;
#(
  parameter int unsigned IMG_W    = 512,
  parameter int unsigned IMG_H    = 512,
  parameter int unsigned H_START  = 385,
  parameter int unsigned V_START  = 21,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       h_sync_i,
  input  logic       v_sync_i,
  input  logic [3:0] red_i,
  input  logic [3:0] green_i,
  input  logic [3:0] blue_i,
  output logic       h_edge_o,
  output logic       v_edge_o,
  output logic       win_o,
  output logic [3:0] red_o,
  output logic [3:0] green_o,
  output logic [3:0] blue_o
);

  localparam logic [CntW-1:0] HLo = CntW'(H_START);
  localparam logic [CntW-1:0] HHi = CntW'(H_START + IMG_W);
  localparam logic [CntW-1:0] VLo = CntW'(V_START);
  localparam logic [CntW-1:0] VHi = CntW'(V_START + IMG_H);

  logic            h_q, h_prev_q, v_q, v_prev_q;
  logic [3:0]      red_q, green_q, blue_q;
  logic [CntW-1:0] h_cnt_q, v_cnt_q;
  logic [CntW-1:0] h_cnt, v_cnt;

  // Input sample registers, previous sync samples and raster counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q      <= 1'b0;
      h_prev_q <= 1'b0;
      v_q      <= 1'b0;
      v_prev_q <= 1'b0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
    end else begin
      h_q      <= h_sync_i;
      h_prev_q <= h_q;
      v_q      <= v_sync_i;
      v_prev_q <= v_q;
      red_q    <= red_i;
      green_q  <= green_i;
      blue_q   <= blue_i;
      h_cnt_q  <= h_cnt;
      v_cnt_q  <= v_cnt;
    end
  end

  // Edge detect and current raster position, aligned with the registered pixel.
  always_comb begin
    h_edge_o = (h_q == SYNC_POL) && (h_prev_q != SYNC_POL);
    v_edge_o = (v_q == SYNC_POL) && (v_prev_q != SYNC_POL);
    h_cnt    = h_edge_o ? '0 : sat_inc(h_cnt_q);
    v_cnt    = v_edge_o ? '0 : (h_edge_o ? sat_inc(v_cnt_q) : v_cnt_q);
    win_o    = (h_cnt >= HLo) && (h_cnt < HHi) && (v_cnt >= VLo) && (v_cnt < VHi);
    red_o    = red_q;
    green_o  = green_q;
    blue_o   = blue_q;
  end

endmodule

// File: rtl/vga_capture.sv
// Frame grabber top: capture FSM, RGB332 packer and image RAM write port.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int unsigned IMG_W    = 512,
  parameter int unsigned IMG_H    = 512,
  parameter int unsigned H_START  = 385,
  parameter int unsigned V_START  = 21,
  parameter int unsigned ADDR_W   = 15,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic              pixel_clk_i,
  input  logic              rst_n_i,
  input  logic              h_sync_i,
  input  logic              v_sync_i,
  input  logic [3:0]        red_i,
  input  logic [3:0]        green_i,
  input  logic [3:0]        blue_i,
  input  logic              capture_en_i,
  input  logic              cont_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              frame_err_o,
  output logic              ram_en_o,
  output logic [7:0]        ram_wen_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [63:0]       ram_wdata_o
);

  localparam int unsigned       NumWords = IMG_W * IMG_H / 8;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NumWords - 1);

  logic       h_edge, v_edge, win;
  logic [3:0] red, green, blue;
  logic [7:0] pixel;
  logic       last_wr;

  cap_state_e        state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [55:0]       word_q, word_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              ram_en_q, ram_en_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [63:0]       ram_wdata_q, ram_wdata_d;

  vga_capture_sync_rx #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .H_START  (H_START),
    .V_START  (V_START),
    .SYNC_POL (SYNC_POL)
  ) u_sync_rx (
    .clk_i    (pixel_clk_i),
    .rst_ni   (rst_n_i),
    .h_sync_i (h_sync_i),
    .v_sync_i (v_sync_i),
    .red_i    (red_i),
    .green_i  (green_i),
    .blue_i   (blue_i),
    .h_edge_o (h_edge),
    .v_edge_o (v_edge),
    .win_o    (win),
    .red_o    (red),
    .green_o  (green),
    .blue_o   (blue)
  );

  // State, packer and registered RAM port.
  always_ff @(posedge pixel_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      word_q      <= '0;
      wcnt_q      <= '0;
      err_q       <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      wcnt_q      <= wcnt_d;
      err_q       <= err_d;
      ram_en_q    <= ram_en_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Next state: arming, frame tracking, packing and word-write scheduling.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    wcnt_d      = wcnt_q;
    err_d       = err_q;
    ram_en_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    pixel       = pack_rgb332(red, green, blue);
    // The strobe currently on the port carries the frame's final word.
    last_wr     = ram_en_q && (ram_addr_q == LastAddr);

    unique case (state_q)
      StIdle: begin
        if (capture_en_i) begin
          state_d = StArmed;
          wcnt_d  = '0;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      StArmed: begin
        if (v_edge) begin
          state_d = StCapture;
          wcnt_d  = '0;
          idx_d   = '0;
        end
      end
      StCapture: begin
        if (last_wr) begin
          // Final write wins over a coincident v-edge.
          state_d = StDone;
        end else if (v_edge) begin
          err_d  = 1'b1;
          wcnt_d = '0;
          idx_d  = '0;
        end else if (win) begin
          if (idx_q == 3'd7) begin
            ram_en_d    = 1'b1;
            ram_addr_d  = wcnt_q;
            ram_wdata_d = {pixel, word_q};
            wcnt_d      = wcnt_q + ADDR_W'(1);
            idx_d       = '0;
          end else begin
            for (int k = 0; k < 7; k++) begin
              if (idx_q == 3'(k)) word_d[k*8 +: 8] = pixel;
            end
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StDone: begin
        state_d = cont_i ? StArmed : StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything except the sticky error flag.
    if (abort_i) begin
      state_d     = StIdle;
      ram_en_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      idx_d       = '0;
      wcnt_d      = '0;
    end
  end

  // Status and RAM outputs straight from registers.
  always_comb begin
    busy_o       = (state_q != StIdle);
    frame_done_o = (state_q == StDone);
    frame_err_o  = err_q;
    ram_en_o     = ram_en_q;
    ram_wen_o    = ram_en_q ? 8'hFF : 8'h00;
    ram_addr_o   = ram_addr_q;
    ram_wdata_o  = ram_wdata_q;
  end

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture: a frame-level model predicts every RAM write
// and done pulse, a compare process checks them each cycle, and directed tests pin
// literal values.
module tb_vga_capture;

  localparam int IW = 16;
  localparam int IH = 2;
  localparam int HS = 4;
  localparam int VS = 1;
  localparam int AW = 3;
  localparam int LineLen = 32;
  localparam int NWords = IW * IH / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          h_sync = 1'b0, v_sync = 1'b0;
  logic [3:0]    red = '0, green = '0, blue = '0;
  logic          capture_en = 1'b0, cont = 1'b0, abort = 1'b0;
  logic          busy_o, frame_done_o, frame_err_o, ram_en_o;
  logic [7:0]    ram_wen_o;
  logic [AW-1:0] ram_addr_o;
  logic [63:0]   ram_wdata_o;

  always #5 clk = ~clk;

  vga_capture #(
    .IMG_W    (IW),
    .IMG_H    (IH),
    .H_START  (HS),
    .V_START  (VS),
    .ADDR_W   (AW),
    .SYNC_POL (1'b1)
  ) dut (
    .pixel_clk_i  (clk),
    .rst_n_i      (rst_n),
    .h_sync_i     (h_sync),
    .v_sync_i     (v_sync),
    .red_i        (red),
    .green_i      (green),
    .blue_i       (blue),
    .capture_en_i (capture_en),
    .cont_i       (cont),
    .abort_i      (abort),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .frame_err_o  (frame_err_o),
    .ram_en_o     (ram_en_o),
    .ram_wen_o    (ram_wen_o),
    .ram_addr_o   (ram_addr_o),
    .ram_wdata_o  (ram_wdata_o)
  );

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [63:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  done_q[$];
  wr_t wlog[$];
  int  dcount = 0;
  int  cyc = 0;
  int  nchk = 0;
  int  nerr = 0;

  // Frame-level model state.
  bit          m_armed = 0, m_cap = 0, m_cont = 0;
  int          m_addr = 0, m_byte = 0, vline = 100;
  logic [63:0] m_word = '0;
  int          t7 = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pk(input logic [3:0] v);
    return {v[3:1], v[3:1], v[3:2]};
  endfunction

  function automatic logic [63:0] wdat(input int i);
    return (i < wlog.size()) ? wlog[i].data : 64'hx;
  endfunction

  function automatic logic [63:0] waddr(input int i);
    return (i < wlog.size()) ? 64'(wlog[i].addr) : 64'hx;
  endfunction

  function automatic int wcyc(input int i);
    return (i < wlog.size()) ? wlog[i].cyc : -1;
  endfunction

  // Frame start seen at the pins: begin a capture if armed, or restart one in flight.
  task automatic model_vedge();
    if (m_cap || m_armed) begin
      m_cap   = 1;
      m_armed = 0;
      m_addr  = 0;
      m_byte  = 0;
    end
  endtask

  // A window pixel driven in cycle dcyc while capturing.
  task automatic model_pixel(input logic [3:0] v, input int dcyc);
    m_word[m_byte*8 +: 8] = pk(v);
    m_byte++;
    if (m_byte == 8) begin
      if (m_addr == 0) t7 = dcyc;
      exp_q.push_back('{cyc: dcyc + 2, addr: AW'(m_addr), data: m_word});
      m_addr++;
      m_byte = 0;
      if (m_addr == NWords) begin
        done_q.push_back(dcyc + 3);
        m_cap   = 0;
        m_armed = m_cont;
      end
    end
  endtask

  // Compare DUT outputs against the model every cycle.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      bit exp_en, exp_d;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("write_missed", 64'(exp_q[0].cyc), 64'(cyc));
        void'(exp_q.pop_front());
      end
      while (done_q.size() > 0 && done_q[0] < cyc) begin
        chk("done_missed", 64'(done_q[0]), 64'(cyc));
        void'(done_q.pop_front());
      end
      exp_en = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("ram_en", 64'(ram_en_o), 64'(exp_en));
      if (ram_en_o) wlog.push_back('{cyc: cyc, addr: ram_addr_o, data: ram_wdata_o});
      if (exp_en) begin
        chk("ram_addr", 64'(ram_addr_o), 64'(exp_q[0].addr));
        chk("ram_wdata", ram_wdata_o, exp_q[0].data);
        chk("ram_wen", 64'(ram_wen_o), 64'h00FF);
        void'(exp_q.pop_front());
      end
      exp_d = (done_q.size() > 0) && (done_q[0] == cyc);
      chk("frame_done", 64'(frame_done_o), 64'(exp_d));
      if (frame_done_o) dcount++;
      if (exp_d) void'(done_q.pop_front());
    end
  end

  // One raster line; abort_col >= 0 pulses abort on that column's pixel.
  task automatic drive_line(input bit vs, input int off, input int ncyc, input int abort_col);
    for (int p = 0; p < ncyc; p++) begin
      int col;
      int tmp;
      logic [3:0] v;
      @(negedge clk);
      if (abort_col >= 0 && p == HS + abort_col + 1) chk("busy_after_abort", 64'(busy_o), 64'd0);
      col    = p - HS;
      tmp    = (col + off) & 15;
      v      = tmp[3:0];
      h_sync = (p == 0);
      v_sync = vs && (p == 0);
      red    = v;
      green  = v;
      blue   = v;
      abort  = (abort_col >= 0) && (p == HS + abort_col);
      if (p == 0) begin
        if (vs) begin
          vline = 0;
          model_vedge();
        end else begin
          vline++;
        end
      end
      if (abort) begin
        m_cap   = 0;
        m_armed = 0;
      end else if (m_cap && vline >= VS && vline < VS + IH && col >= 0 && col < IW) begin
        model_pixel(v, cyc);
      end
    end
  endtask

  task automatic frame(input int off);
    drive_line(1, off, LineLen, -1);
    for (int l = 0; l < 3; l++) drive_line(0, off, LineLen, -1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      h_sync = 0;
      v_sync = 0;
      abort  = 0;
    end
  endtask

  task automatic arm();
    @(negedge clk);
    capture_en = 1;
    @(negedge clk);
    capture_en = 0;
    m_armed = 1;
  endtask

  task automatic check_normal_frame(input string tag);
    chk({tag, "_nwrites"}, 64'(wlog.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk({tag, "_addr"}, waddr(i), 64'(i));
    chk({tag, "_word0"}, wdat(0), 64'h6D6D4949_24240000);
    chk({tag, "_word1"}, wdat(1), 64'hFFFFDBDB_B6B69292);
    chk({tag, "_done_pulses"}, 64'(dcount), 64'd1);
    chk({tag, "_busy_end"}, 64'(busy_o), 64'd0);
    chk({tag, "_err"}, 64'(frame_err_o), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_ram", {ram_en_o, ram_wen_o, ram_addr_o, frame_done_o, frame_err_o}, 64'd0);
    chk("reset_wdata", ram_wdata_o, 64'd0);
    rst_n = 1;
    idle(4);

    // Test 1/2: single frame, column-indexed pixels, plus latency.
    wlog.delete();
    dcount = 0;
    arm();
    chk("t1_busy_armed", 64'(busy_o), 64'd1);
    frame(0);
    idle(8);
    check_normal_frame("t1");
    chk("t2_latency", 64'(wcyc(0) - t7), 64'd2);

    // Test 3: continuous mode over three frames.
    wlog.delete();
    dcount = 0;
    cont   = 1;
    m_cont = 1;
    arm();
    frame(1);
    frame(2);
    cont   = 0;
    m_cont = 0;
    frame(3);
    idle(8);
    chk("t3_nwrites", 64'(wlog.size()), 64'd12);
    for (int i = 0; i < 12; i++) chk("t3_addr", waddr(i), 64'(i % 4));
    chk("t3_done_pulses", 64'(dcount), 64'd3);
    chk("t3_err", 64'(frame_err_o), 64'd0);
    chk("t3_busy_end", 64'(busy_o), 64'd0);

    // Test 4: frame restarts after two words.
    wlog.delete();
    dcount = 0;
    arm();
    drive_line(1, 4, LineLen, -1);
    drive_line(0, 4, LineLen, -1);
    drive_line(1, 4, LineLen, -1);
    for (int l = 0; l < 3; l++) drive_line(0, 4, LineLen, -1);
    idle(8);
    chk("t4_err", 64'(frame_err_o), 64'd1);
    chk("t4_nwrites", 64'(wlog.size()), 64'd6);
    chk("t4_restart_addr", waddr(2), 64'd0);
    chk("t4_last_addr", waddr(5), 64'd3);
    chk("t4_done_pulses", 64'(dcount), 64'd1);
    chk("t4_busy_end", 64'(busy_o), 64'd0);

    // Test 5: abort mid-word, then re-arm with a fresh frame.
    arm();
    chk("t5_err_cleared", 64'(frame_err_o), 64'd0);
    wlog.delete();
    dcount = 0;
    drive_line(1, 0, LineLen, -1);
    drive_line(0, 7, LineLen, 6);
    idle(8);
    chk("t5_no_write", 64'(wlog.size()), 64'd0);
    chk("t5_busy_idle", 64'(busy_o), 64'd0);
    arm();
    frame(5);
    idle(8);
    chk("t5_nwrites", 64'(wlog.size()), 64'd4);
    chk("t5_first_addr", waddr(0), 64'd0);
    chk("t5_first_word", wdat(0), 64'hDBB6B692_926D6D49);
    chk("t5_done_pulses", 64'(dcount), 64'd1);

    // Test 6: asynchronous reset in the middle of a capture.
    wlog.delete();
    dcount = 0;
    arm();
    drive_line(1, 0, LineLen, -1);
    drive_line(0, 0, LineLen, -1);
    drive_line(0, 0, 16, -1);
    chk("t6_writes_before_reset", 64'(wlog.size()), 64'd3);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_busy", 64'(busy_o), 64'd0);
    chk("t6_rst_ram", {ram_en_o, ram_wen_o, ram_addr_o, frame_done_o, frame_err_o}, 64'd0);
    chk("t6_rst_wdata", ram_wdata_o, 64'd0);
    exp_q.delete();
    done_q.delete();
    m_cap   = 0;
    m_armed = 0;
    h_sync  = 0;
    v_sync  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    idle(4);
    wlog.delete();
    dcount = 0;
    arm();
    frame(0);
    idle(8);
    check_normal_frame("t6");

    chk("exp_writes_drained", 64'(exp_q.size()), 64'd0);
    chk("exp_done_drained", 64'(done_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
